riscv_lsu: RTL and testbench

Load-store unit between the single-cycle RISC-V core's data-memory port and the data memory. It sits directly downstream of the core. It turns the core's request into a word-aligned memory transaction with byte enables and aligned store data, and sign- or zero-extends load data. It holds the core with `core_stall_o` until the memory handshake completes. A small FSM sequences each access so the core sees exactly one non-stalled cycle per memory instruction.

---
 rtl/riscv_lsu.sv | 146 ++++++++++++++
 tb/tb_riscv_lsu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_lsu.sv
`timescale 1ns/1ps
// riscv_lsu
// Load-store unit between a single-cycle RISC-V core and a word-wide data
// memory. Each core memory instruction is sequenced IDLE -> BUSY -> DONE.
// The core is stalled until the memory handshake completes and then sees
// exactly one non-stalled cycle in which the extended load data is valid.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   core_req_i/we_i       core access request, 1 = store
//   core_size_i           funct3 size code (B/H/W/BU/HU; 3,6,7 act as W)
//   core_addr_i/wd_i      byte address, right-justified store data
//   core_rd_o             registered, extended load data
//   core_stall_o          hold the core while the access is in flight
//   mem_req_o/we_o/be_o   memory request, write enable, byte enables
//   mem_addr_o/wd_o       word address, lane-replicated store data
//   mem_rd_i/ready_i      memory read word and completion strobe
module riscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic [31:0] core_rd_o,
    output logic        core_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    input  logic        mem_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] rd_reg;
    logic        capture;

    logic [1:0]  off;
    logic        is_byte;
    logic        is_half;
    logic        is_unsigned;
    logic [3:0]  be_access;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    assign off         = core_addr_i[1:0];
    // Only 0/4 are bytes and 1/5 halves; every other code is a full word.
    assign is_byte     = (core_size_i == 3'd0) || (core_size_i == 3'd4);
    assign is_half     = (core_size_i == 3'd1) || (core_size_i == 3'd5);
    assign is_unsigned = core_size_i[2];

    assign mem_addr_o  = {core_addr_i[31:2], 2'b00};

    always_comb begin
        be_access = 4'b1111;
        if (is_byte) begin
            be_access = 4'b0001 << off;
        end else if (is_half) begin
            be_access = off[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Store data is replicated across lanes so the byte enables alone pick
    // the destination; the memory never needs the offset.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign mem_wd_o[8*gi +: 8] = is_byte ? core_wd_i[7:0] :
                                         is_half ? core_wd_i[8*(gi%2) +: 8] :
                                                   core_wd_i[8*gi +: 8];
        end
    endgenerate

    assign ld_byte = mem_rd_i[{off, 3'b000} +: 8];
    assign ld_half = off[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];

    always_comb begin
        ld_ext = mem_rd_i;
        if (is_byte) begin
            ld_ext = {{24{~is_unsigned & ld_byte[7]}}, ld_byte};
        end else if (is_half) begin
            ld_ext = {{16{~is_unsigned & ld_half[15]}}, ld_half};
        end
    end

    always_comb begin
        state_next   = state_reg;
        core_stall_o = 1'b0;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        mem_be_o     = 4'b0000;
        capture      = 1'b0;
        case (state_reg)
            IDLE: begin
                core_stall_o = core_req_i;
                if (core_req_i) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                core_stall_o = 1'b1;
                mem_req_o    = 1'b1;
                mem_we_o     = core_we_i;
                mem_be_o     = be_access;
                if (mem_ready_i) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                // Core retires at the next edge; returning to IDLE guarantees
                // a back-to-back request is seen as a fresh access.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            rd_reg    <= 32'd0;
        end else begin
            state_reg <= state_next;
            if (capture) begin
                rd_reg <= ld_ext;
            end
        end
    end

    assign core_rd_o = rd_reg;

endmodule

// File: tb/tb_riscv_lsu.sv
`timescale 1ns/1ps
module tb_riscv_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    riscv_lsu dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .core_req_i   (core_req_i),
        .core_we_i    (core_we_i),
        .core_size_i  (core_size_i),
        .core_addr_i  (core_addr_i),
        .core_wd_i    (core_wd_i),
        .core_rd_o    (core_rd_o),
        .core_stall_o (core_stall_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wd_o     (mem_wd_o),
        .mem_rd_i     (mem_rd_i),
        .mem_ready_i  (mem_ready_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, expv);
        end
    endtask

    // Reference model: lane arithmetic straight from the access rules.
    function automatic exp_t model(input logic we, input logic [2:0] size,
                                   input logic [31:0] addr, input logic [31:0] wd,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          nb;
        int          start;
        int          be_i;
        bit          sgn;
        logic [31:0] mask;
        logic [31:0] v;
        case (size)
            3'd0, 3'd4: nb = 1;
            3'd1, 3'd5: nb = 2;
            default:    nb = 4;
        endcase
        sgn   = (size == 3'd0) || (size == 3'd1);
        start = (nb == 4) ? 0 : (nb == 2) ? 2 * int'(addr[1]) : int'(addr[1:0]);
        be_i  = ((1 << nb) - 1) << start;
        e.be  = be_i[3:0];
        for (int i = 0; i < 4; i++) begin
            e.wd[8*i +: 8] = wd[8*(i % nb) +: 8];
        end
        v = rdata >> (8 * start);
        if (nb < 4) begin
            mask = (32'h1 << (8 * nb)) - 32'h1;
            v    = v & mask;
            if (sgn && v[8*nb-1]) v = v | ~mask;
        end
        e.rd   = v;
        e.addr = {addr[31:2], 2'b00};
        e.we   = we;
        return e;
    endfunction

    // Driver: one access with a given number of wait cycles in BUSY. The
    // stall/request cycle counts encode the IDLE/BUSY/DONE sequence.
    task automatic do_access(input logic we, input logic [2:0] size,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdata, input int waits);
        exp_t e;
        int   stall_cnt = 0;
        int   req_cnt   = 0;
        e = model(we, size, addr, wd, rdata);
        exp_q.push_back(e);
        last_rd = e.rd;
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = we;
        core_size_i = size;
        core_addr_i = addr;
        core_wd_i   = wd;
        mem_ready_i = 1'b0;
        mem_rd_i    = $urandom;
        for (int k = 0; k < waits + 3; k++) begin
            if (k > 0) begin
                @(posedge clk_i); #1;
                mem_ready_i = (k == waits + 1);
                mem_rd_i    = (k == waits + 1) ? rdata : $urandom;
            end
            @(negedge clk_i);
            if (core_stall_o) stall_cnt++;
            if (mem_req_o)    req_cnt++;
        end
        $display("txn we=%0d size=%0d addr=%08h wd=%08h rdata=%08h waits=%0d exp_rd=%08h",
                 we, size, addr, wd, rdata, waits, e.rd);
        chk("stall_cycles", 32'(stall_cnt), 32'(waits + 2));
        chk("req_cycles",   32'(req_cnt),   32'(waits + 1));
    endtask

    task automatic idle_cycle();
        @(posedge clk_i); #1;
        core_req_i  = 1'b0;
        mem_ready_i = 1'b0;
    endtask

    // Monitor: a completed handshake pops one expectation; the following
    // cycle must be the single un-stalled DONE cycle with the load result.
    initial begin
        exp_t e;
        bit   done_pending = 0;
        forever begin
            @(negedge clk_i);
            if (done_pending) begin
                chk("done_stall", 32'(core_stall_o), 32'd0);
                chk("done_req",   32'(mem_req_o),    32'd0);
                chk("core_rd",    core_rd_o,         e.rd);
                done_pending = 0;
            end
            if (!rst_i && mem_req_o && mem_ready_i) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_handshake: got handshake expected none");
                end else begin
                    e = exp_q.pop_front();
                    chk("mem_we",   32'(mem_we_o), 32'(e.we));
                    chk("mem_be",   32'(mem_be_o), 32'(e.be));
                    chk("mem_addr", mem_addr_o,    e.addr);
                    chk("mem_wd",   mem_wd_o,      e.wd);
                    done_pending = 1;
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [2:0] size_tab [8];

    initial begin
        size_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        rst_i       = 1'b1;
        core_req_i  = 1'b0;
        core_we_i   = 1'b0;
        core_size_i = 3'd0;
        core_addr_i = 32'd0;
        core_wd_i   = 32'd0;
        mem_rd_i    = 32'd0;
        mem_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("reset_stall", 32'(core_stall_o), 32'd0);
        chk("reset_req",   32'(mem_req_o),    32'd0);
        chk("reset_we",    32'(mem_we_o),     32'd0);
        chk("reset_be",    32'(mem_be_o),     32'd0);
        chk("reset_rd",    core_rd_o,         32'd0);

        // Directed cases
        do_access(1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h1234_5678, 0);
        do_access(1'b0, 3'd0, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 0);
        do_access(1'b0, 3'd4, 32'h0000_2003, 32'h0, 32'h80FF_7F01, 0);
        do_access(1'b0, 3'd0, 32'h0000_2001, 32'h0, 32'h80FF_7F01, 0);
        do_access(1'b0, 3'd1, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 0);
        do_access(1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'h80FF_7F01, 0);
        do_access(1'b0, 3'd2, 32'h0000_2000, 32'h0, 32'h80FF_7F01, 0);
        do_access(1'b0, 3'd1, 32'h0000_3004, 32'h0, 32'hCAFE_8001, 3);
        idle_cycle();
        @(negedge clk_i);
        chk("rd_hold", core_rd_o, last_rd);

        // Reset in the middle of BUSY, with a ready in the reset cycle
        @(posedge clk_i); #1;
        core_req_i  = 1'b1;
        core_we_i   = 1'b0;
        core_size_i = 3'd2;
        core_addr_i = 32'h0000_4000;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("busy_req", 32'(mem_req_o), 32'd1);
        @(posedge clk_i); #1;
        rst_i       = 1'b1;
        mem_ready_i = 1'b1;
        mem_rd_i    = 32'hDEAD_BEEF;
        @(posedge clk_i); #1;
        rst_i       = 1'b0;
        mem_ready_i = 1'b0;
        core_req_i  = 1'b0;
        @(negedge clk_i);
        chk("rst_req",   32'(mem_req_o),    32'd0);
        chk("rst_stall", 32'(core_stall_o), 32'd0);
        chk("rst_rd",    core_rd_o,         32'd0);
        do_access(1'b0, 3'd2, 32'h0000_5000, 32'h0, 32'h1111_2222, 0);
        do_access(1'b0, 3'd2, 32'h0000_5004, 32'h0, 32'h3333_4444, 0);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            do_access(1'($urandom), size_tab[$urandom_range(0, 7)], $urandom, $urandom,
                      $urandom, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();
        repeat (2) @(negedge clk_i);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
